// File: rtl/microtile_bist_pkg.sv
// microtile_bist_pkg: shared states, polynomial tap masks and constants for the microtile BIST driver.
package microtile_bist_pkg;
  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, FINISH} state_t;
  localparam logic [7:0] LFSR_TAPS = 8'hB8;
  localparam int MISR_W = 16;
  localparam logic [MISR_W-1:0] MISR_TAPS = 16'hD008;
  localparam logic [7:0] IDLE_DRIVE = 8'h00;
endpackage

// File: rtl/microtile_misr.sv
// microtile_misr: 16-bit multiple-input signature register folding an 8-bit response into its low byte.
module microtile_misr
  import microtile_bist_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              en,
  input  logic [7:0]        din,
  output logic [MISR_W-1:0] sig
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sig <= '0;
    else if (clear) sig <= '0;
    else if (en) sig <= {sig[MISR_W-2:0], ^(sig & MISR_TAPS)} ^ {{(MISR_W-8){1'b0}}, din};
endmodule

// File: rtl/microtile_bist_driver.sv
// microtile_bist_driver: LFSR stimulus into a microtile, MISR compaction of its response, golden compare.
module microtile_bist_driver
  import microtile_bist_pkg::*;
#(
  parameter int         NUM_VECTORS   = 256,
  parameter int         SETTLE_CYCLES = 2,
  parameter logic [7:0] SEED          = 8'h01
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] expected,
  output logic [7:0]  stim,
  input  logic [7:0]  resp,
  output logic        busy,
  output logic        done,
  output logic [15:0] signature,
  output logic        pass
);
  localparam logic [7:0] SEED_EFF = (SEED == 8'h00) ? 8'h01 : SEED;
  localparam int VW = $clog2(NUM_VECTORS + 1);
  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  state_t state, state_nxt;
  logic [VW-1:0] vec_cnt;
  logic [SW-1:0] set_cnt;
  logic settled, last, load;
  assign settled = set_cnt == SW'(SETTLE_CYCLES - 1);
  assign last    = vec_cnt == VW'(NUM_VECTORS - 1);
  assign load    = (state == IDLE) && start;
  assign busy    = (state == SETTLE) || (state == SAMPLE);
  assign done    = state == FINISH;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = start ? SETTLE : IDLE;
      SETTLE:  state_nxt = settled ? SAMPLE : SETTLE;
      SAMPLE:  state_nxt = last ? FINISH : SETTLE;
      default: state_nxt = IDLE;
    endcase
  end
  // stim doubles as the LFSR state; it is reseeded on every start
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      stim    <= IDLE_DRIVE;
      vec_cnt <= '0;
      set_cnt <= '0;
      pass    <= 1'b0;
    end else if (load) begin
      stim    <= SEED_EFF;
      vec_cnt <= '0;
      set_cnt <= '0;
      pass    <= 1'b0;
    end else begin
      case (state)
        SETTLE: if (!settled) set_cnt <= set_cnt + 1'b1;
        SAMPLE: begin
          stim    <= {stim[6:0], ^(stim & LFSR_TAPS)};
          vec_cnt <= vec_cnt + 1'b1;
          set_cnt <= '0;
        end
        FINISH: begin
          pass <= signature == expected;
          stim <= IDLE_DRIVE;
        end
        default: ;
      endcase
    end
  microtile_misr u_misr (
    .clk  (clk),
    .rst_n(rst_n),
    .clear(load),
    .en   (state == SAMPLE),
    .din  (resp),
    .sig  (signature)
  );
endmodule

// File: tb/tb_microtile_bist_driver.sv
// tb_microtile_bist_driver: directed checks of three driver configurations sharing one clock and reset.
module tb_microtile_bist_driver;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  int n_checks = 0;
  int n_pass = 0;
  logic start_a = 0, start_b = 0, start_c = 0;
  logic [7:0] resp_a = 8'h00, resp_b = 8'hA5, resp_c;
  logic [15:0] exp_a = 16'h0000, exp_b = 16'h0000, exp_c = 16'h0000;
  logic [7:0] stim_a, stim_b, stim_c;
  logic busy_a, busy_b, busy_c, done_a, done_b, done_c, pass_a, pass_b, pass_c;
  logic [15:0] sig_a, sig_b, sig_c;
  microtile_bist_driver #(.NUM_VECTORS(6), .SETTLE_CYCLES(1)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .expected(exp_a), .stim(stim_a), .resp(resp_a),
    .busy(busy_a), .done(done_a), .signature(sig_a), .pass(pass_a));
  microtile_bist_driver #(.NUM_VECTORS(2)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .expected(exp_b), .stim(stim_b), .resp(resp_b),
    .busy(busy_b), .done(done_b), .signature(sig_b), .pass(pass_b));
  microtile_bist_driver u_c (
    .clk(clk), .rst_n(rst_n), .start(start_c), .expected(exp_c), .stim(stim_c), .resp(resp_c),
    .busy(busy_c), .done(done_c), .signature(sig_c), .pass(pass_c));
  // reference microtile: an arbitrary mix of rotate and add
  function automatic logic [7:0] tile(input logic [7:0] s);
    return {s[0], s[7:1]} ^ (s + 8'h5A);
  endfunction
  assign resp_c = tile(stim_c);
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic run_c(output int n);
    start_c = 1;
    tick;
    start_c = 0;
    n = 1;
    while (!done_c && n < 2000) begin
      tick;
      n++;
    end
  endtask
  logic [7:0] seq_a [6] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11, 8'h23};
  initial begin
    logic [7:0] l;
    logic [15:0] m;
    int n, done_at;
    bit saw_done;
    l = 8'h01;
    m = 16'h0000;
    for (int v = 0; v < 256; v++) begin
      m = {m[14:0], m[15] ^ m[14] ^ m[12] ^ m[3]} ^ {8'h00, tile(l)};
      l = {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    end
    exp_c = m;
    repeat (2) tick;
    rst_n = 1;
    for (int i = 0; i < 10; i++) begin
      check("reset_idle", {stim_a, busy_a, done_a, sig_a, pass_a}, 32'h0);
      tick;
    end
    start_a = 1;
    tick;
    start_a = 0;
    for (int c = 1; c <= 12; c++) begin
      check("a_stim", {stim_a, done_a}, {seq_a[(c-1)/2], 1'b0});
      tick;
    end
    check("a_done13", {done_a, busy_a}, 2'b10);
    check("a_sig", sig_a, 16'h0000);
    tick;
    check("a_pass", {pass_a, done_a}, 2'b10);
    exp_b = 16'h01EF;
    start_b = 1;
    tick;
    start_b = 0;
    repeat (3) tick;
    check("b_sig1", sig_b, 16'h00A5);
    repeat (3) tick;
    check("b_done", {done_b, sig_b}, {1'b1, 16'h01EF});
    tick;
    check("b_pass1", pass_b, 1'b1);
    exp_b = 16'h01EE;
    start_b = 1;
    tick;
    start_b = 0;
    check("b_clear", {pass_b, sig_b}, 17'h0);
    repeat (6) tick;
    check("b_done2", {done_b, sig_b}, {1'b1, 16'h01EF});
    tick;
    check("b_pass0", pass_b, 1'b0);
    start_c = 1;
    tick;
    start_c = 0;
    done_at = 0;
    for (int cyc = 1; cyc <= 900; cyc++) begin
      start_c = (cyc == 2) || (cyc >= 769);
      if (cyc == 766) check("c_wrap", stim_c, 8'h01);
      if (done_c) begin
        done_at = cyc;
        break;
      end
      tick;
    end
    check("c_done_at", done_at, 769);
    check("c_busy_fin", busy_c, 1'b0);
    tick;
    check("c_idle", {busy_c, pass_c}, 2'b01);
    check("c_sig", sig_c, exp_c);
    tick;
    start_c = 0;
    check("c_restart", {busy_c, stim_c}, {1'b1, 8'h01});
    n = 1;
    while (!done_c && n < 2000) begin
      tick;
      n++;
    end
    check("c2_done_at", n, 769);
    tick;
    check("c2_sig", sig_c, exp_c);
    check("c2_pass", pass_c, 1'b1);
    start_c = 1;
    tick;
    start_c = 0;
    repeat (6) tick;
    check("c_pre_rst", busy_c, 1'b1);
    #2 rst_n = 0;
    #1 check("c_async_rst", {stim_c, busy_c, done_c, sig_c, pass_c}, 32'h0);
    @(posedge clk);
    #4 rst_n = 1;
    saw_done = 0;
    for (int i = 0; i < 40; i++) begin
      tick;
      saw_done |= done_c;
    end
    check("c_no_done", {saw_done, busy_c, sig_c}, 32'h0);
    run_c(n);
    check("c3_done_at", n, 769);
    tick;
    check("c3_result", {pass_c, sig_c}, {1'b1, exp_c});
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
